// File: rtl/dmem_responder.sv
// Data-memory slave for the RV32I load/store port: one access at a time, WAIT_CYCLES
// wait states, sized stores, sign/zero-extended loads, misalignment/illegal-size flag.
module dmem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned WORDS     = 2 ** (ADDR_W - 2);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              commit;

  logic [DATA_W-1:0] mem [WORDS];

  logic [ADDR_W-1:0] a_c;
  logic [2:0]        f3_c;
  logic [DATA_W-1:0] wd_c;
  logic              wr_c;
  logic              bad;
  logic [3:0]        be;
  logic [DATA_W-1:0] wlane;
  logic [DATA_W-1:0] word;
  logic [7:0]        lb;
  logic [15:0]       lh;
  logic [DATA_W-1:0] ldval;

  // With zero wait states the access commits on the accept edge, so the live
  // request is used; otherwise the captured copy is.
  always_comb begin
    if (state_q == S_IDLE) begin
      a_c  = addr;
      f3_c = Funct3;
      wd_c = wr_data;
      wr_c = MemWrite;
    end else begin
      a_c  = addr_q;
      f3_c = f3_q;
      wd_c = wdata_q;
      wr_c = wr_q;
    end
  end

  always_comb begin
    bad = !(f3_c inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
          || (f3_c[1:0] == 2'b01 && a_c[0])
          || (f3_c[1:0] == 2'b10 && a_c[1:0] != 2'b00);
    case (f3_c[1:0])
      2'b00:   begin be = 4'b0001 << a_c[1:0];              wlane = {4{wd_c[7:0]}};  end
      2'b01:   begin be = a_c[1] ? 4'b1100 : 4'b0011;       wlane = {2{wd_c[15:0]}}; end
      default: begin be = 4'b1111;                          wlane = wd_c;            end
    endcase
    word = mem[a_c[ADDR_W-1:2]];
    case (a_c[1:0])
      2'b00:   lb = word[7:0];
      2'b01:   lb = word[15:8];
      2'b10:   lb = word[23:16];
      default: lb = word[31:24];
    endcase
    lh = a_c[1] ? word[31:16] : word[15:0];
    case (f3_c[1:0])
      2'b00:   ldval = {{24{lb[7]  & ~f3_c[2]}}, lb};
      2'b01:   ldval = {{16{lh[15] & ~f3_c[2]}}, lh};
      default: ldval = word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = addr;
          f3_d    = Funct3;
          wdata_d = wr_data;
          wr_d    = MemWrite;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = commit ? bad : err_q;
    rd_d  = (commit && !wr_c && !bad) ? ldval : rd_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // RAM is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (reset && commit && wr_c && !bad) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[a_c[ADDR_W-1:2]][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign ready   = (state_q == S_RESP);
  assign busy    = (state_q != S_IDLE);
  assign err     = ready && err_q;
  assign rd_data = rd_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle/multicycle RISC-V core: the slave end of the core's load/store port (MemRead/MemWrite, byte address, write data, Funct3). It accepts one access at a time and inserts a configurable number of wait states. It performs RV32I sized stores (SB/SH/SW) and sign/zero-extended loads (LB/LH/LW/LBU/LHU), and flags misaligned or illegal accesses. It sits between the datapath's memory stage and the on-chip word-organised RAM, and drives the handshake the datapath stalls on.

## Interface
- DATA_W, 32, data width (fixed at 32 for RV32I sizing)
- ADDR_W, 9, byte-address width; RAM holds 2**(ADDR_W-2) words
- WAIT_CYCLES, 1, extra wait states per access (0..15)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- MemRead  in  1  load request strobe, sampled only in IDLE
- MemWrite  in  1  store request strobe, sampled only in IDLE
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_W  byte address
- wr_data  in  DATA_W  store data; bytes come from the low end (SB uses [7:0], SH uses [15:0])
- rd_data  out  DATA_W  extended load result, held until the next successful load
- ready  out  1  one-cycle completion pulse
- busy  out  1  high while an access is in flight (WAIT or RESP)
- err  out  1  pulses with ready when the access was misaligned or Funct3 was illegal

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If MemWrite or MemRead is high, capture addr, Funct3, wr_data and the type.
  - MemWrite has priority when both are high; the access is treated as a store only.
  - Next state is WAIT if WAIT_CYCLES>0, with the counter loaded to WAIT_CYCLES-1; otherwise RESP.
- WAIT: the counter decrements each cycle. At 0, perform the access on the transition edge and go to RESP.
- RESP: ready=1 for exactly this cycle, then IDLE. Strobes during WAIT or RESP are ignored; the core holds its stall on busy.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Funct3 values 011, 110 and 111 are illegal.
  - A misaligned or illegal access does not update RAM or rd_data, and err=1 in RESP.
- Store: word index is addr[ADDR_W-1:2]. Byte lanes:
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Unwritten lanes are preserved (little-endian).
- Load: the word is read and the lane selected as for stores. B/H are sign-extended and BU/HU zero-extended to 32 bits, then registered into rd_data.
- RAM contents are not affected by reset.

## Timing
- Request sampled at edge T (state IDLE, strobe high).
- The access takes effect at the edge ending cycle T+WAIT_CYCLES.
- ready/err are high during cycle T+1+WAIT_CYCLES.
- rd_data is valid from that cycle until the next completing load.
- busy is high for cycles T+1 .. T+1+WAIT_CYCLES.
- Earliest next accept is in cycle T+2+WAIT_CYCLES, so throughput is one access per WAIT_CYCLES+2 cycles.
- Reset values: state IDLE, counter 0, rd_data 0, ready 0, busy 0, err 0.
- Reset mid-operation (WAIT or RESP, reset low at an edge) returns to IDLE with outputs at reset values. No ready is produced, and a store that has not yet reached its commit edge is discarded.
- Reset held low: strobes are ignored.

## Test plan
- WAIT_CYCLES=1; SW 0xDEADBEEF @0x010, then LW @0x010: ready 2 cycles after each accept, busy 2 cycles, rd_data=0xDEADBEEF, err=0.
- After the above, SB wr_data=0x00000080 @0x011:
  - LB @0x011 -> 0xFFFFFF80; LBU @0x011 -> 0x00000080; LW @0x010 -> 0xDEAD80EF.
  - SH 0x1234 @0x012, then LH @0x012 -> 0x00001234; LHU @0x010 -> 0x000080EF.
- Misaligned and illegal accesses:
  - LH @0x013 -> ready=1, err=1, rd_data unchanged.
  - SW @0x012 -> err=1; LW @0x010 is still 0x123480EF.
  - Funct3=011 -> err=1.
- MemRead and MemWrite both high with SW 0xA5A5A5A5 @0x020: a store occurs, rd_data unchanged. Strobes toggled during busy produce no extra ready.
- reset low during WAIT of SW 0x11111111 @0x030: no ready, outputs 0. A subsequent LW @0x030 returns the prior contents.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: ready exactly 1 and 4 cycles after accept respectively; back-to-back strobes are accepted every 2 and 5 cycles.
